riscv_div_serial: RTL

// - Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU ops; the inverse-operation

---
 rtl/riscv_div_serial_if.sv | 24 ++
 rtl/riscv_div_serial.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/riscv_div_serial_if.sv
// Request/response bundle between the EX stage and the serial divider.
// The master drives the operation and retire strobe; the divider answers with the result and stall.
interface riscv_div_serial_if #(
    parameter int WIDTH = 32
);
    logic             enable_i;
    logic [1:0]       operator_i;
    logic [WIDTH-1:0] op_a_i;
    logic [WIDTH-1:0] op_b_i;
    logic [WIDTH-1:0] result_o;
    logic             multicycle_o;
    logic             ready_o;
    logic             ex_ready_i;

    modport master (
        output enable_i, operator_i, op_a_i, op_b_i, ex_ready_i,
        input  result_o, multicycle_o, ready_o
    );

    modport slave (
        input  enable_i, operator_i, op_a_i, op_b_i, ex_ready_i,
        output result_o, multicycle_o, ready_o
    );
endinterface

// File: rtl/riscv_div_serial.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle on
// magnitudes, with divide-by-zero and signed-overflow resolved at accept.
module riscv_div_serial #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    riscv_div_serial_if.slave   div_if
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_b_mag;
    logic [WIDTH-1:0] r_result;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_rem_op;

    logic             w_ready;
    logic             w_sign_a;
    logic             w_sign_b;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_div0;
    logic             w_ovf;
    logic [WIDTH+1:0] w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_lo;
    logic             w_rem_hi;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_final;

    // Operand decode at accept; unsigned ops never carry a sign.
    assign w_sign_a = ~div_if.operator_i[0] & div_if.op_a_i[WIDTH-1];
    assign w_sign_b = ~div_if.operator_i[0] & div_if.op_b_i[WIDTH-1];
    assign w_abs_a  = w_sign_a ? (~div_if.op_a_i + 1'b1) : div_if.op_a_i;
    assign w_abs_b  = w_sign_b ? (~div_if.op_b_i + 1'b1) : div_if.op_b_i;
    assign w_div0   = (div_if.op_b_i == '0);
    assign w_ovf    = ~div_if.operator_i[0] && (div_if.op_a_i == MIN_NEG) && (div_if.op_b_i == '1);

    // One restoring step: shift quo MSB into rem, keep the trial difference when it is non-negative.
    assign w_trial   = {r_rem, r_quo[WIDTH-1]} - {2'b00, r_b_mag};
    assign w_ge      = ~w_trial[WIDTH+1];
    assign w_rem_lo  = w_ge ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
    assign w_rem_hi  = w_ge ? w_trial[WIDTH] : r_rem[WIDTH-1];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

    // Remainder follows the dividend sign; quotient is negative when the signs differ.
    always_comb begin
        w_final = w_quo_nxt;
        if (r_rem_op) begin
            w_final = r_sign_a ? (~w_rem_lo + 1'b1) : w_rem_lo;
        end else if (r_sign_a ^ r_sign_b) begin
            w_final = ~w_quo_nxt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = ~div_if.enable_i;
                if (div_if.enable_i) begin
                    w_state_nxt = (w_div0 || w_ovf) ? FINISH : DIVIDE;
                end
            end
            DIVIDE: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = FINISH;
                end
            end
            FINISH: begin
                w_ready = 1'b1;
                if (div_if.ex_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_b_mag  <= '0;
            r_result <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_rem_op <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (div_if.enable_i) begin
                        r_rem_op <= div_if.operator_i[1];
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_b_mag  <= w_abs_b;
                        r_quo    <= w_abs_a;
                        r_rem    <= '0;
                        r_cnt    <= CW'(WIDTH);
                        if (w_div0) begin
                            r_result <= div_if.operator_i[1] ? div_if.op_a_i : '1;
                        end else if (w_ovf) begin
                            r_result <= div_if.operator_i[1] ? '0 : MIN_NEG;
                        end
                    end
                end
                DIVIDE: begin
                    r_rem <= {w_rem_hi, w_rem_lo};
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_result <= w_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_if.result_o     = r_result;
    assign div_if.ready_o      = w_ready;
    assign div_if.multicycle_o = ~w_ready;
endmodule
